e_event_filter: RTL and testbench

Downstream consumer of the two-phase registered output `E` of the multiphase clocking stage. It glitch-filters `E` with a configurable run-length qualifier and detects qualified rising edges. It counts those edges in a saturating counter and publishes a count snapshot per edge over a valid/ready interface. All logic runs on the posedge of `Clk`; `E` is already posedge-registered upstream, so no synchroniser is instantiated.

---
 rtl/e_event_filter_if.sv | 36 +++
 rtl/e_event_filter.sv | 223 ++++++++++++++++++++++
 tb/tb_e_event_filter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/e_event_filter_if.sv
// -----------------------------------------------------------------------------
// e_event_filter_if
//
// Snapshot channel of the event filter: a plain valid/ready handshake that
// carries one count snapshot per accepted rising edge.
//
// Signals
//   Evt_Valid  producer -> consumer  snapshot available
//   Evt_Ready  consumer -> producer  consumer accepts snapshot
//   Evt_Data   producer -> consumer  count value captured with the snapshot
//
// Modports
//   master  the filter (drives Evt_Valid/Evt_Data, samples Evt_Ready)
//   slave   the consumer
// -----------------------------------------------------------------------------
interface e_event_filter_if #(
    parameter int unsigned CNT_W = 8
) ();

    logic             Evt_Valid;
    logic             Evt_Ready;
    logic [CNT_W-1:0] Evt_Data;

    modport master (
        output Evt_Valid,
        output Evt_Data,
        input  Evt_Ready
    );

    modport slave (
        input  Evt_Valid,
        input  Evt_Data,
        output Evt_Ready
    );

endinterface

// File: rtl/e_event_filter.sv
// -----------------------------------------------------------------------------
// e_event_filter
//
// Glitch filter and rising-edge counter for the two-phase registered output E
// of the multiphase clocking stage. E is already registered on the posedge of
// Clk upstream, so it is used directly without a synchroniser.
//
// A level change of E is accepted only after FILT_LEN consecutive identical
// samples. Each accepted 0->1 change produces a one-cycle Rise pulse, bumps a
// saturating counter and publishes the new count as a snapshot over the
// valid/ready channel. A rise that finds the previous snapshot still pending
// is counted but not published; Drop pulses instead.
//
// Parameters
//   FILT_LEN  consecutive samples needed to accept a level change (1..15)
//   CNT_W     width of the event counter and snapshot (2..16)
//
// Ports
//   Clk    in   sole clock, posedge only
//   Rst    in   synchronous active-high reset, overrides all other inputs
//   E      in   raw event level from the upstream stage
//   Clr    in   synchronous clear of Count and Sat
//   Level  out  filtered level of E
//   Rise   out  one-cycle pulse per accepted 0->1 of Level
//   Count  out  saturating count of accepted rises
//   Sat    out  sticky, set by a rise accepted while Count is all-ones
//   Drop   out  one-cycle pulse, rise occurred while a snapshot was pending
//   evt    snapshot channel (master side): Evt_Valid, Evt_Ready, Evt_Data
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.
// -----------------------------------------------------------------------------
module e_event_filter #(
    parameter int unsigned FILT_LEN = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             E,
    input  logic             Clr,
    output logic             Level,
    output logic             Rise,
    output logic [CNT_W-1:0] Count,
    output logic             Sat,
    output logic             Drop,
    e_event_filter_if.master evt
);

    // Run-length target in the width of the filter counter.
    localparam logic [3:0]       FiltLenW = 4'(FILT_LEN);
    localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        StLow,
        StL2H,
        StHigh,
        StH2L
    } state_e;

    // Filter state
    state_e           state_q, state_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic [3:0]       fcnt_inc;
    logic             enter_high;
    logic             enter_q;
    logic             level_q;
    logic             rise_q;

    // Counter and snapshot state
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] data_q, data_d;
    logic             drop_q, drop_d;

    // -------------------------------------------------------------------------
    // Qualifier FSM: LOW/HIGH are the settled levels, L2H/H2L count a run of
    // opposite samples in fcnt. A sample that breaks the run aborts back to
    // the settled level.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        enter_high = 1'b0;
        fcnt_inc   = fcnt_q + 4'd1;

        case (state_q)
            StLow: begin
                if (E) begin
                    if (FILT_LEN == 1) begin
                        state_d    = StHigh;
                        fcnt_d     = 4'd0;
                        enter_high = 1'b1;
                    end else begin
                        state_d = StL2H;
                        fcnt_d  = 4'd1;
                    end
                end
            end

            StL2H: begin
                if (!E) begin
                    state_d = StLow;
                    fcnt_d  = 4'd0;
                end else if (fcnt_inc == FiltLenW) begin
                    state_d    = StHigh;
                    fcnt_d     = 4'd0;
                    enter_high = 1'b1;
                end else begin
                    fcnt_d = fcnt_inc;
                end
            end

            StHigh: begin
                if (!E) begin
                    if (FILT_LEN == 1) begin
                        state_d = StLow;
                        fcnt_d  = 4'd0;
                    end else begin
                        state_d = StH2L;
                        fcnt_d  = 4'd1;
                    end
                end
            end

            StH2L: begin
                if (E) begin
                    state_d = StHigh;
                    fcnt_d  = 4'd0;
                end else if (fcnt_inc == FiltLenW) begin
                    state_d = StLow;
                    fcnt_d  = 4'd0;
                end else begin
                    fcnt_d = fcnt_inc;
                end
            end

            default: begin
                state_d = StLow;
                fcnt_d  = 4'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Counter and snapshot, driven by the registered Rise so they update one
    // cycle after the Rise pulse.
    // -------------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        valid_d = valid_q;
        data_d  = data_q;
        drop_d  = 1'b0;

        // Clear first, so a coincident rise counts from zero.
        if (Clr) begin
            count_d = '0;
            sat_d   = 1'b0;
        end

        if (rise_q) begin
            if (count_d == CntMax) begin
                sat_d = 1'b1;
            end else begin
                count_d = count_d + 1'b1;
            end
        end

        // A handshake in the same cycle as a rise frees the slot for the new
        // snapshot, so Evt_Valid stays high.
        if (rise_q) begin
            if (!valid_q || evt.Evt_Ready) begin
                valid_d = 1'b1;
                data_d  = count_d;
            end else begin
                drop_d = 1'b1;
            end
        end else if (valid_q && evt.Evt_Ready) begin
            valid_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StLow;
            fcnt_q  <= 4'd0;
            level_q <= 1'b0;
            enter_q <= 1'b0;
            rise_q  <= 1'b0;
            count_q <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            level_q <= (state_d == StHigh) || (state_d == StH2L);
            // Entry to HIGH is flagged in the cycle the FSM lands there; Rise
            // follows one cycle later.
            enter_q <= enter_high;
            rise_q  <= enter_q;
            count_q <= count_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign Level         = level_q;
    assign Rise          = rise_q;
    assign Count         = count_q;
    assign Sat           = sat_q;
    assign Drop          = drop_q;
    assign evt.Evt_Valid = valid_q;
    assign evt.Evt_Data  = data_q;

endmodule

// File: tb/tb_e_event_filter.sv
// -----------------------------------------------------------------------------
// tb_e_event_filter
//
// Three instances share one set of inputs:
//   dut 0: FILT_LEN=3, CNT_W=8   (directed vector table)
//   dut 1: FILT_LEN=3, CNT_W=2   (saturation sequence)
//   dut 2: FILT_LEN=1, CNT_W=8   (unfiltered tracking sequence)
// A reference model, derived from the level/edge/count rules, checks every
// output of every instance on each negedge; random stimulus follows the
// directed parts.
// -----------------------------------------------------------------------------
module tb_e_event_filter;

    logic Clk;
    logic Rst;
    logic E;
    logic Clr;
    logic Evt_Ready;

    logic       lvl_a, rise_a, sat_a, drop_a;
    logic [7:0] cnt_a;
    logic       lvl_b, rise_b, sat_b, drop_b;
    logic [1:0] cnt_b;
    logic       lvl_c, rise_c, sat_c, drop_c;
    logic [7:0] cnt_c;

    e_event_filter_if #(.CNT_W(8)) if_a ();
    e_event_filter_if #(.CNT_W(2)) if_b ();
    e_event_filter_if #(.CNT_W(8)) if_c ();

    assign if_a.Evt_Ready = Evt_Ready;
    assign if_b.Evt_Ready = Evt_Ready;
    assign if_c.Evt_Ready = Evt_Ready;

    e_event_filter #(.FILT_LEN(3), .CNT_W(8)) dut_a (
        .Clk(Clk), .Rst(Rst), .E(E), .Clr(Clr), .Level(lvl_a), .Rise(rise_a),
        .Count(cnt_a), .Sat(sat_a), .Drop(drop_a), .evt(if_a)
    );
    e_event_filter #(.FILT_LEN(3), .CNT_W(2)) dut_b (
        .Clk(Clk), .Rst(Rst), .E(E), .Clr(Clr), .Level(lvl_b), .Rise(rise_b),
        .Count(cnt_b), .Sat(sat_b), .Drop(drop_b), .evt(if_b)
    );
    e_event_filter #(.FILT_LEN(1), .CNT_W(8)) dut_c (
        .Clk(Clk), .Rst(Rst), .E(E), .Clr(Clr), .Level(lvl_c), .Rise(rise_c),
        .Count(cnt_c), .Sat(sat_c), .Drop(drop_c), .evt(if_c)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------------------------------------------------------- model
    int          flen [3] = '{3, 3, 1};
    int          cmax [3] = '{255, 3, 255};
    logic [15:0] m_hist [3];
    bit          m_level [3];
    bit          m_lvl_prev [3];
    bit          m_rise [3];
    int          m_cnt [3];
    bit          m_sat [3];
    bit          m_valid [3];
    int          m_data [3];
    bit          m_drop [3];
    bit          chk_en = 1'b0;

    // Level flips once the last FILT_LEN samples all disagree with it; Rise is
    // the 0->1 edge of Level seen one cycle late; count/snapshot follow Rise.
    task automatic model_step(input int i);
        logic [15:0] mask;
        mask = 16'((1 << flen[i]) - 1);
        if (Rst) begin
            m_hist[i] = '0; m_level[i] = 0; m_lvl_prev[i] = 0; m_rise[i] = 0;
            m_cnt[i] = 0; m_sat[i] = 0; m_valid[i] = 0; m_data[i] = 0; m_drop[i] = 0;
        end else begin
            m_drop[i] = 0;
            if (m_rise[i]) begin
                if (Clr) begin m_cnt[i] = 1; m_sat[i] = 0; end
                else if (m_cnt[i] == cmax[i]) m_sat[i] = 1;
                else m_cnt[i]++;
                if (!m_valid[i] || Evt_Ready) begin
                    m_valid[i] = 1; m_data[i] = m_cnt[i];
                end else m_drop[i] = 1;
            end else begin
                if (Clr) begin m_cnt[i] = 0; m_sat[i] = 0; end
                if (m_valid[i] && Evt_Ready) m_valid[i] = 0;
            end
            m_rise[i]     = m_level[i] && !m_lvl_prev[i];
            m_lvl_prev[i] = m_level[i];
            m_hist[i]     = {m_hist[i][14:0], E};
            if (!m_level[i] && ((m_hist[i] & mask) == mask)) m_level[i] = 1;
            else if (m_level[i] && ((m_hist[i] & mask) == 16'd0)) m_level[i] = 0;
        end
    endtask

    always @(posedge Clk) begin
        for (int i = 0; i < 3; i++) model_step(i);
        chk_en <= 1'b1;
    end

    task automatic chk_dut(input int id, input logic lvl, input logic rise, input int cnt,
                           input logic sat, input logic v, input int d, input logic drop);
        check($sformatf("dut%0d Level", id), int'(lvl), int'(m_level[id]));
        check($sformatf("dut%0d Rise", id), int'(rise), int'(m_rise[id]));
        check($sformatf("dut%0d Count", id), cnt, m_cnt[id]);
        check($sformatf("dut%0d Sat", id), int'(sat), int'(m_sat[id]));
        check($sformatf("dut%0d Evt_Valid", id), int'(v), int'(m_valid[id]));
        check($sformatf("dut%0d Evt_Data", id), d, m_data[id]);
        check($sformatf("dut%0d Drop", id), int'(drop), int'(m_drop[id]));
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            chk_dut(0, lvl_a, rise_a, int'(cnt_a), sat_a, if_a.Evt_Valid,
                    int'(if_a.Evt_Data), drop_a);
            chk_dut(1, lvl_b, rise_b, int'(cnt_b), sat_b, if_b.Evt_Valid,
                    int'(if_b.Evt_Data), drop_b);
            chk_dut(2, lvl_c, rise_c, int'(cnt_c), sat_c, if_c.Evt_Valid,
                    int'(if_c.Evt_Data), drop_c);
        end
    end

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic rst, e, clr, rdy;
        logic lvl, rise;
        int   cnt;
        logic v;
        int   d;
        logic drop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int rst, input int e, input int clr, input int rdy,
                                input int lvl, input int rise, input int cnt, input int v,
                                input int d, input int drop);
        vec_t r;
        r.rst = (rst != 0); r.e = (e != 0); r.clr = (clr != 0); r.rdy = (rdy != 0);
        r.lvl = (lvl != 0); r.rise = (rise != 0); r.cnt = cnt; r.v = (v != 0);
        r.d = d; r.drop = (drop != 0);
        return r;
    endfunction

    task automatic cycle();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        E = 1'b1;
        for (int k = 0; k < hi; k++) cycle();
        E = 1'b0;
        for (int k = 0; k < lo; k++) cycle();
    endtask

    int hold;
    int n_rise_c;

    initial begin
        Rst = 1'b1; E = 1'b0; Clr = 1'b0; Evt_Ready = 1'b0;

        // rst  e clr rdy | lvl rise cnt v d drop   (expected for dut 0)
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // 0  reset
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // 1  glitch, 2 samples
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // 5  qualified edge, k=5
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0)); // 7  Level at k+2
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0)); // 8  Rise
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 1, 1, 0)); // 9  count/snapshot
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 1, 0)); // 13 second rise, stalled
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 2, 1, 1, 1)); // 17 Drop
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2, 1, 1, 0)); // 19 third rise, stalled
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 2, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 2, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 3, 1, 1, 1)); // 23 Drop again
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 3, 0, 1, 0)); // 24 handshake
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 3, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 3, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 1, 0)); // 27 Clr, snapshot kept
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 1, 1, 0)); // 33
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1, 1, 1, 0)); // 40 Rise
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 2, 1, 2, 0)); // 41 handshake + rise
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 2, 0, 2, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 2, 0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 2, 0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 2, 0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2, 0, 2, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2, 0, 2, 0)); // 47 reset mid-L2H
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2, 0, 2, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 1, 1, 0));

        foreach (tbl[i]) begin
            Rst = tbl[i].rst; E = tbl[i].e; Clr = tbl[i].clr; Evt_Ready = tbl[i].rdy;
            cycle();
            check($sformatf("row%0d Level", i), int'(lvl_a), int'(tbl[i].lvl));
            check($sformatf("row%0d Rise", i), int'(rise_a), int'(tbl[i].rise));
            check($sformatf("row%0d Count", i), int'(cnt_a), tbl[i].cnt);
            check($sformatf("row%0d Evt_Valid", i), int'(if_a.Evt_Valid), int'(tbl[i].v));
            check($sformatf("row%0d Evt_Data", i), int'(if_a.Evt_Data), tbl[i].d);
            check($sformatf("row%0d Drop", i), int'(drop_a), int'(tbl[i].drop));
        end

        // Saturation on the 2-bit counter, then Clr coincident with Rise.
        Rst = 1'b1; E = 1'b0; Clr = 1'b0; Evt_Ready = 1'b1;
        cycle();
        Rst = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            pulse(4, 4);
            check($sformatf("sat pulse%0d Count", n), int'(cnt_b), (n < 3) ? n : 3);
            check($sformatf("sat pulse%0d Sat", n), int'(sat_b), (n == 4) ? 1 : 0);
        end
        E = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        check("sat fifth Rise", int'(rise_b), 1);
        Clr = 1'b1; E = 1'b0;
        cycle();
        Clr = 1'b0;
        check("clr+rise Count", int'(cnt_b), 1);
        check("clr+rise Sat", int'(sat_b), 0);
        check("clr+rise Evt_Data", int'(if_b.Evt_Data), 1);
        for (int k = 0; k < 4; k++) cycle();

        // FILT_LEN=1: Level follows E one cycle late, one Rise per high phase.
        Rst = 1'b1; E = 1'b0;
        cycle();
        Rst = 1'b0;
        n_rise_c = 0;
        for (int c = 0; c < 24; c++) begin
            E = c[1];
            cycle();
            check($sformatf("flen1 c%0d Level", c), int'(lvl_c), int'(E));
            if (rise_c) n_rise_c++;
        end
        E = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            if (rise_c) n_rise_c++;
        end
        check("flen1 Rise pulses", n_rise_c, 6);
        check("flen1 Count", int'(cnt_c), 6);

        // Random runs of E with sporadic Clr, backpressure and reset.
        hold = 0;
        for (int t = 0; t < 3000; t++) begin
            if (hold == 0) begin
                E    = ($urandom_range(0, 1) != 0);
                hold = int'($urandom_range(1, 7));
            end
            hold--;
            Clr       = ($urandom_range(0, 39) == 0);
            Evt_Ready = ($urandom_range(0, 2) != 0);
            Rst       = ($urandom_range(0, 299) == 0);
            cycle();
        end

        Rst = 1'b0; Clr = 1'b0; E = 1'b0;
        cycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
